// File: rtl/hamming_byte_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : hamming_byte_assembler_if
// Purpose  : Byte-assembler stream bundle. It carries the codeword input
//            strobe and the ready/valid byte output with its error flag.
// Ports    : io_input[7:0]  codeword from the serial receive stage
//            io_inValid     one-cycle codeword strobe
//            io_output[7:0] assembled byte
//            io_outValid    byte pending
//            io_outReady    consumer accepts the byte
//            io_outErr      byte holds an uncorrectable nibble
// Modports : master = codeword source / byte consumer side
//            slave  = assembler side
// Revision : 1.0 - initial release
// ============================================================================
interface hamming_byte_assembler_if;
  logic [7:0] io_input;
  logic       io_inValid;
  logic [7:0] io_output;
  logic       io_outValid;
  logic       io_outReady;
  logic       io_outErr;

  modport master (
    output io_input, io_inValid, io_outReady,
    input  io_output, io_outValid, io_outErr
  );

  modport slave (
    input  io_input, io_inValid, io_outReady,
    output io_output, io_outValid, io_outErr
  );
endinterface
`default_nettype wire

// File: rtl/hamming_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : hamming_byte_assembler
// Purpose  : Decodes 8-bit SECDED codewords (4 data bits each), pairs a high
//            and a low nibble into a byte and presents the byte on a
//            one-entry ready/valid output register. It flags uncorrectable
//            nibbles, counts dropped bytes (sticky overflow) and drops a lone
//            high nibble after TIMEOUT_CYCLES idle cycles.
// Params   : TIMEOUT_CYCLES  max idle cycles between high and low codeword
// Macro    : HAMMING_STATS_EN  when defined, the corrected/uncorrectable
//            codeword counters are implemented. When undefined, both count
//            outputs are 0 and io_clearStats is ignored.
// Ports    : clock           rising-edge clock
//            reset           asynchronous active-low reset
//            bus             stream bundle (slave modport)
//            io_sync         realign: drop held high nibble
//            io_clearStats   synchronous clear of both counters
//            io_overflow     sticky: a completed byte was dropped
//            io_timeout      one-cycle pulse: held nibble timed out
//            io_corrCount    saturating corrected-codeword count
//            io_uncorrCount  saturating uncorrectable-codeword count
// Revision : 1.0 - initial release
// ============================================================================
module hamming_byte_assembler #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic                clock,
  input  wire logic                reset,
  hamming_byte_assembler_if.slave  bus,
  input  wire logic                io_sync,
  input  wire logic                io_clearStats,
  output logic                     io_overflow,
  output logic                     io_timeout,
  output logic [15:0]              io_corrCount,
  output logic [15:0]              io_uncorrCount
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  // --------------------------------------------------------------------------
  // SECDED decode (combinational, registered in stage 1)
  // --------------------------------------------------------------------------
  logic [7:0] cw;
  logic [7:0] fixed_cw;
  logic [2:0] syndrome;
  logic       parity;
  logic [3:0] dec_nibble;
  logic       dec_uncorr;
  logic       dec_corr;

  always_comb begin
    cw       = bus.io_input;
    syndrome = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    parity   = ^cw;
    fixed_cw = cw;
    dec_uncorr = 1'b0;
    dec_corr   = 1'b0;
    if (syndrome != 3'd0 && parity) begin
      // Single error: the syndrome gives the 1-based position of the bad bit.
      fixed_cw = cw ^ (8'd1 << (syndrome - 3'd1));
      dec_corr = 1'b1;
    end else if (syndrome == 3'd0 && parity) begin
      // Only the overall parity bit is wrong; the data bits are intact.
      dec_corr = 1'b1;
    end else if (syndrome != 3'd0 && !parity) begin
      dec_uncorr = 1'b1;
    end
    dec_nibble = {fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};
  end

  // --------------------------------------------------------------------------
  // Stage 1: decoded codeword register
  // --------------------------------------------------------------------------
  logic       s1_valid;
  logic [3:0] s1_nibble;
  logic       s1_uncorr;
  logic       s1_corr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_nibble <= 4'd0;
      s1_uncorr <= 1'b0;
      s1_corr   <= 1'b0;
    end else begin
      s1_valid <= bus.io_inValid;
      if (bus.io_inValid) begin
        s1_nibble <= dec_nibble;
        s1_uncorr <= dec_uncorr;
        s1_corr   <= dec_corr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: nibble pairing FSM and output register
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    high_nibble;
  logic          high_err;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_err;
  logic          overflow;
  logic          timeout_pulse;
  logic          accept;

  assign accept = out_valid && bus.io_outReady;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_HIGH;
      timer         <= '0;
      high_nibble   <= 4'd0;
      high_err      <= 1'b0;
      out_data      <= 8'd0;
      out_valid     <= 1'b0;
      out_err       <= 1'b0;
      overflow      <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      if (accept) begin
        out_valid <= 1'b0;
      end

      if (io_sync) begin
        // Realign: behave as if in HIGH, so a same-cycle decoded codeword
        // becomes the new high nibble.
        timer <= '0;
        if (s1_valid) begin
          high_nibble <= s1_nibble;
          high_err    <= s1_uncorr;
          state       <= ST_LOW;
        end else begin
          state <= ST_HIGH;
        end
      end else begin
        case (state)
          ST_HIGH: begin
            if (s1_valid) begin
              high_nibble <= s1_nibble;
              high_err    <= s1_uncorr;
              timer       <= '0;
              state       <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (s1_valid) begin
              state <= ST_HIGH;
              if (!out_valid || accept) begin
                out_data  <= {high_nibble, s1_nibble};
                out_err   <= high_err | s1_uncorr;
                out_valid <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else if (timer == TIMER_MAX) begin
              state         <= ST_HIGH;
              timer         <= '0;
              timeout_pulse <= 1'b1;
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end
          default: begin
            state <= ST_HIGH;
            timer <= '0;
          end
        endcase
      end
    end
  end

  assign bus.io_output   = out_data;
  assign bus.io_outValid = out_valid;
  assign bus.io_outErr   = out_err;
  assign io_overflow     = overflow;
  assign io_timeout      = timeout_pulse;

  // --------------------------------------------------------------------------
  // Statistics counters
  // --------------------------------------------------------------------------
`ifdef HAMMING_STATS_EN
  logic [15:0] corr_count;
  logic [15:0] uncorr_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      corr_count   <= 16'd0;
      uncorr_count <= 16'd0;
    end else if (io_clearStats) begin
      corr_count   <= 16'd0;
      uncorr_count <= 16'd0;
    end else if (s1_valid) begin
      if (s1_corr && corr_count != 16'hFFFF) begin
        corr_count <= corr_count + 16'd1;
      end
      if (s1_uncorr && uncorr_count != 16'hFFFF) begin
        uncorr_count <= uncorr_count + 16'd1;
      end
    end
  end

  assign io_corrCount   = corr_count;
  assign io_uncorrCount = uncorr_count;
`else
  logic [1:0] unused_stats;
  assign unused_stats   = {io_clearStats, s1_corr};
  assign io_corrCount   = 16'd0;
  assign io_uncorrCount = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_byte_assembler
// Purpose  : Self-checking bench for hamming_byte_assembler. A table of
//            codeword pairs is driven through the DUT. Expected bytes go
//            into a scoreboard queue, and a negedge monitor pops and compares
//            them on each accepted output. Hand-written sequences cover
//            latency, timeout, sync, overflow and mid-byte reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_byte_assembler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_sync = 1'b0;
  logic        io_clearStats = 1'b0;
  logic        io_overflow;
  logic        io_timeout;
  logic [15:0] io_corrCount;
  logic [15:0] io_uncorrCount;

  always #5 clock = ~clock;

  hamming_byte_assembler_if bus ();

  hamming_byte_assembler #(.TIMEOUT_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .io_sync        (io_sync),
    .io_clearStats  (io_clearStats),
    .io_overflow    (io_overflow),
    .io_timeout     (io_timeout),
    .io_corrCount   (io_corrCount),
    .io_uncorrCount (io_uncorrCount)
  );

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] exp_byte;
    logic       exp_err;
    int         corr_inc;
    int         unc_inc;
  } vec_t;

  typedef struct packed {
    logic [7:0] b;
    logic       e;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int timeout_seen = 0;
  int exp_corr = 0;
  int exp_unc = 0;
  int a0;
  int t0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] cw);
    bus.io_input   = cw;
    bus.io_inValid = 1'b1;
    tick();
    bus.io_inValid = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic e);
    exp_t x;
    x.b = b;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic check_counts(input string tag);
`ifdef HAMMING_STATS_EN
    check({tag, "_corrCount"}, {16'd0, io_corrCount}, exp_corr);
    check({tag, "_uncorrCount"}, {16'd0, io_uncorrCount}, exp_unc);
`else
    check({tag, "_corrCount"}, {16'd0, io_corrCount}, 32'd0);
    check({tag, "_uncorrCount"}, {16'd0, io_uncorrCount}, 32'd0);
`endif
  endtask

  // Scoreboard monitor: one pop per accepted byte, plus timeout pulse count.
  always @(negedge clock) begin
    exp_t e;
    if (reset && bus.io_outValid && bus.io_outReady) begin
      accepted++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h, none expected", bus.io_output);
      end else begin
        e = sb.pop_front();
        check("out_byte", {24'd0, bus.io_output}, {24'd0, e.b});
        check("out_err", {31'd0, bus.io_outErr}, {31'd0, e.e});
      end
    end
    if (reset && io_timeout) timeout_seen++;
  end

  initial begin
    vecs[0] = '{hi: 8'hFF, lo: 8'h00, exp_byte: 8'hF0, exp_err: 1'b0, corr_inc: 0, unc_inc: 0};
    vecs[1] = '{hi: 8'h04, lo: 8'h80, exp_byte: 8'h00, exp_err: 1'b0, corr_inc: 2, unc_inc: 0};
    vecs[2] = '{hi: 8'h03, lo: 8'hFF, exp_byte: 8'h0F, exp_err: 1'b1, corr_inc: 0, unc_inc: 1};
    vecs[3] = '{hi: 8'hD2, lo: 8'h2D, exp_byte: 8'hA5, exp_err: 1'b0, corr_inc: 0, unc_inc: 0};
    vecs[4] = '{hi: 8'h92, lo: 8'h2C, exp_byte: 8'hA5, exp_err: 1'b0, corr_inc: 2, unc_inc: 0};
    vecs[5] = '{hi: 8'h2D, lo: 8'h39, exp_byte: 8'h56, exp_err: 1'b1, corr_inc: 0, unc_inc: 1};

    bus.io_input    = 8'h00;
    bus.io_inValid  = 1'b0;
    bus.io_outReady = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_output", {24'd0, bus.io_output}, 32'h00);
    check("rst_outValid", {31'd0, bus.io_outValid}, 32'd0);
    check("rst_outErr", {31'd0, bus.io_outErr}, 32'd0);
    check("rst_overflow", {31'd0, io_overflow}, 32'd0);
    check("rst_timeout", {31'd0, io_timeout}, 32'd0);
    check_counts("rst");
    reset = 1'b1;
    tick();

    // Latency: low strobe accepted at edge E, outValid high only after E+2
    send(8'hFF);
    send(8'h00);
    push(8'hF0, 1'b0);
    @(negedge clock);
    check("lat_n1_outValid", {31'd0, bus.io_outValid}, 32'd0);
    @(negedge clock);
    check("lat_n2_outValid", {31'd0, bus.io_outValid}, 32'd1);
    @(negedge clock);
    check("lat_n3_outValid", {31'd0, bus.io_outValid}, 32'd0);
    tick();

    // Table-driven codeword pairs
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].hi);
      send(vecs[i].lo);
      push(vecs[i].exp_byte, vecs[i].exp_err);
      exp_corr += vecs[i].corr_inc;
      exp_unc  += vecs[i].unc_inc;
      repeat (3) tick();
      check_counts("vec");
    end

    // Longest allowed gap: 4 idle cycles must still pair, no timeout
    t0 = timeout_seen;
    send(8'hFF);
    repeat (4) tick();
    send(8'h00);
    push(8'hF0, 1'b0);
    repeat (4) tick();
    check("gap_no_timeout", timeout_seen - t0, 32'd0);

    // Sync in the same cycle as a decoded codeword: held FF dropped,
    // the 00 becomes the high nibble.
    send(8'hFF);
    send(8'h00);
    io_sync = 1'b1;
    tick();
    io_sync = 1'b0;
    send(8'hFF);
    push(8'h0F, 1'b0);
    repeat (4) tick();

    // Overflow: consumer stalled, second byte dropped
    bus.io_outReady = 1'b0;
    send(8'hFF);
    send(8'hFF);
    push(8'hFF, 1'b0);
    send(8'h00);
    send(8'h00);
    repeat (3) tick();
    check("ovf_output", {24'd0, bus.io_output}, 32'hFF);
    check("ovf_outValid", {31'd0, bus.io_outValid}, 32'd1);
    check("ovf_overflow", {31'd0, io_overflow}, 32'd1);
    a0 = accepted;
    bus.io_outReady = 1'b1;
    repeat (4) tick();
    check("ovf_one_byte", accepted - a0, 32'd1);
    check("ovf_sticky", {31'd0, io_overflow}, 32'd1);

    // Timeout of a lone high nibble, then a clean pair
    t0 = timeout_seen;
    send(8'hFF);
    repeat (10) tick();
    check("timeout_pulses", timeout_seen - t0, 32'd1);
    send(8'h00);
    send(8'hFF);
    push(8'h0F, 1'b0);
    repeat (4) tick();
    check_counts("pre_rst");

    // Reset with a high nibble held
    send(8'hFF);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_overflow", {31'd0, io_overflow}, 32'd0);
    exp_corr = 0;
    exp_unc  = 0;
    check_counts("async_rst");
    tick();
    reset = 1'b1;
    tick();
    a0 = accepted;
    t0 = timeout_seen;
    send(8'h00);
    send(8'h00);
    push(8'h00, 1'b0);
    repeat (4) tick();
    check("rst_seq_one_byte", accepted - a0, 32'd1);
    check("rst_seq_overflow", {31'd0, io_overflow}, 32'd0);
    check("rst_seq_timeout", timeout_seen - t0, 32'd0);

    // Counter clear
    send(8'h04);
    send(8'h80);
    push(8'h00, 1'b0);
    exp_corr += 2;
    repeat (3) tick();
    check_counts("pre_clear");
    io_clearStats = 1'b1;
    tick();
    io_clearStats = 1'b0;
    exp_corr = 0;
    exp_unc  = 0;
    tick();
    check_counts("post_clear");

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_byte_assembler.md
HAMMING_BYTE_ASSEMBLER -- requirements
Module: hamming_byte_assembler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles allowed between the high-nibble and low-nibble codewords of one byte.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting (0) forces reset state immediately, release is synchronous to clock.
REQ-004 io_input  input  8  SECDED codeword from the serial receive stage.
REQ-005 io_inValid  input  1  one-cycle strobe: io_input holds a new codeword this cycle.
REQ-006 io_sync  input  1  realign: discard any held high nibble; the next codeword is a high nibble.
REQ-007 io_clearStats  input  1  synchronous clear of both statistics counters.
REQ-008 io_output  output  8  assembled data byte.
REQ-009 io_outValid  output  1  io_output holds an unaccepted byte.
REQ-010 io_outReady  input  1  consumer accepts the byte when io_outValid&io_outReady.
REQ-011 io_outErr  output  1  byte contains at least one uncorrectable nibble; valid with io_outValid.
REQ-012 io_overflow  output  1  sticky: a completed byte was dropped.
REQ-013 io_timeout  output  1  one-cycle pulse: a held high nibble was discarded by timeout.
REQ-014 io_corrCount  output  16  saturating count of corrected codewords.
REQ-015 io_uncorrCount  output  16  saturating count of uncorrectable codewords.

Function
REQ-016 Codeword bit map: b0=p1, b1=p2, b2=d1, b3=p4, b4=d2, b5=d3, b6=d4, b7=overall even parity over b0..b6; nibble={d4,d3,d2,d1}.
REQ-017 Syndrome s={b3^b4^b5^b6, b1^b2^b5^b6, b0^b2^b4^b6}; P = XOR of b0..b7.
REQ-018 Classification: s=0,P=0 clean; s!=0,P=1 single error, invert bit position s (1..7) before extraction; s=0,P=1 error in b7 only, data unchanged, counts as corrected; s!=0,P=0 uncorrectable, data extracted uncorrected.
REQ-019 Stage 1: codeword is decoded and registered one cycle after io_inValid (nibble, uncorrectable flag, corrected flag, valid).
REQ-020 Stage 2 FSM: HIGH (wait for high nibble) and LOW (high nibble held).
REQ-021 HIGH + decoded valid: store nibble as bits [7:4] and its error flag, clear timer, go LOW.
REQ-022 LOW + decoded valid: form byte {high, low}, errFlag = OR of both flags, present to output register, go HIGH.
REQ-023 Latency: io_inValid of the low codeword in cycle N -> io_outValid=1 in cycle N+2 (output register empty or being accepted).
REQ-024 LOW: timer increments each cycle without decoded valid; at timer=TIMEOUT_CYCLES, discard nibble, pulse io_timeout, go HIGH.
REQ-025 io_sync=1: FSM to HIGH, timer cleared, stage-1 result of the same cycle still processed afterward as a high nibble; output register unaffected.
REQ-026 Output register: one byte; loads when empty or accepted in the same cycle; holds io_output/io_outErr stable while io_outValid&!io_outReady.
REQ-027 Completed byte while output register full and not accepted that cycle: byte dropped, io_overflow set until reset.
REQ-028 Counters increment once per classified codeword, saturate at 0xFFFF; io_clearStats wins over a same-cycle increment.

Reset
REQ-029 Reset state: FSM HIGH, timer 0, stage-1 valid 0, io_output=0x00, io_outValid=0, io_outErr=0, io_overflow=0, io_timeout=0, both counters 0.
REQ-030 Reset mid-byte discards held nibble and any in-flight codeword; no byte is emitted for it.

Configuration
REQ-031 Macro HAMMING_STATS_EN defined: io_corrCount and io_uncorrCount implemented per REQ-028.
REQ-032 HAMMING_STATS_EN undefined: counter registers absent, both outputs tied to 0, io_clearStats ignored; all other behaviour identical.

Verification
REQ-033 Codewords 0xFF then 0x00, io_outReady=1 -> io_output=0xF0, io_outErr=0, one io_outValid pulse two cycles after second strobe.
REQ-034 Codewords 0x04 then 0x80 -> io_output=0x00, io_outErr=0, io_corrCount=2 (with HAMMING_STATS_EN).
REQ-035 Codewords 0x03 then 0xFF -> io_outErr=1, io_uncorrCount=1, io_output[3:0]=0xF.
REQ-036 io_outReady=0, four codewords 0xFF,0xFF,0x00,0x00 -> io_output stays 0xFF, io_overflow=1; after io_outReady=1 no second byte appears.
REQ-037 TIMEOUT_CYCLES=4, single codeword 0xFF then idle -> io_timeout pulse; next pair 0x00,0xFF -> io_output=0x0F.
REQ-038 Assert reset (0) with high nibble held, release, send 0x00,0x00 -> io_output=0x00, exactly one io_outValid, all flags 0.
